// File: rtl/sprite_lb_pkg.sv
// sprite_lb_pkg: entry layout, draw FSM states and pixel merge rule for the sprite line buffer
package sprite_lb_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DRAW} state_t;

  typedef struct packed {
    logic we;
    logic shade;
  } merge_t;

  function automatic int shadow_bit(input int planes, input int pal_w);
    return planes + pal_w;
  endfunction

  function automatic int entry_w(input int planes, input int pal_w);
    return shadow_bit(planes, pal_w) + 1;
  endfunction

  function automatic merge_t merge_op(input logic c_zero, input logic c_ones, input logic shadow_en,
                                      input logic prio_first, input logic e_empty);
    merge_t m;
    m.shade = shadow_en & c_ones;
    m.we = ~c_zero & (m.shade | ~prio_first | e_empty);
    return m;
  endfunction

endpackage

// File: rtl/sprite_lb_bank.sv
// sprite_lb_bank: one line bank, single write port and registered read port
module sprite_lb_bank #(
  parameter int AW = 9,
  parameter int DW = 13
) (
  input  logic          clk_24M,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  // write port plus registered read
  always_ff @(posedge clk_24M) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/sprite_linebuf_gen.sv
// sprite_linebuf_gen: double-buffered sprite line buffer, RMW draw side and clear-after-read scan side
module sprite_linebuf_gen
  import sprite_lb_pkg::*;
#(
  parameter int PLANES     = 4,
  parameter int ROW_PX     = 8,
  parameter int LINE_W     = 512,
  parameter int PAL_W      = 8,
  parameter int PRIO_FIRST = 0,
  parameter int AW         = $clog2(LINE_W)
) (
  input  logic                     clk_24M,
  input  logic                     nRES,
  input  logic                     ce_wr,
  input  logic                     ce_px,
  input  logic                     line_start,
  input  logic                     flip_x,
  input  logic                     shadow_en,
  input  logic                     spr_load,
  output logic                     spr_ready,
  input  logic [AW-1:0]            spr_x,
  input  logic                     spr_hflip,
  input  logic [PAL_W-1:0]         spr_pal,
  input  logic [PLANES*ROW_PX-1:0] spr_planes,
  output logic [PAL_W+PLANES-1:0]  pix_out,
  output logic                     pix_opaque,
  output logic                     shadow,
  output logic                     busy,
  output logic                     overrun
);
  localparam int EW = entry_w(PLANES, PAL_W);
  localparam int SB = shadow_bit(PLANES, PAL_W);
  localparam int IW = ROW_PX > 1 ? $clog2(ROW_PX) : 1;

  state_t                   state;
  logic                     bank_sel, hflip_l, s2_valid, s2_fwd, sv;
  logic [AW-1:0]            init_cnt, x_l, rd_x, sa, s2_addr, addr, scan_a, draw_ra, scan_ra;
  logic [PAL_W-1:0]         pal_l, s2_pal;
  logic [PLANES*ROW_PX-1:0] planes_l;
  logic [IW-1:0]            px_i, col;
  logic [PLANES-1:0]        c, s2_col;
  logic [EW-1:0]            fwd_ent, e, merged, rd_d, rd_s;
  logic [EW-1:0]            rdb [2];
  logic                     init, ls, s1_fire, accept, draw_we, clr_we;
  merge_t                   m;

  assign init      = state == ST_INIT;
  assign ls        = line_start & ~init;
  assign spr_ready = state == ST_IDLE;
  assign busy      = (state != ST_IDLE) | s2_valid;
  assign accept    = spr_load & spr_ready & ce_wr;
  assign s1_fire   = (state == ST_DRAW) & ce_wr & ~ls;
  assign addr      = x_l + AW'(px_i);
  assign draw_ra   = s1_fire ? addr : s2_addr;
  assign scan_a    = flip_x ? AW'(LINE_W-1) - rd_x : rd_x;
  assign scan_ra   = ce_px ? scan_a : sa;
  assign rd_d      = bank_sel ? rdb[1] : rdb[0];
  assign rd_s      = bank_sel ? rdb[0] : rdb[1];
  assign e         = s2_fwd ? fwd_ent : rd_d;
  assign m         = merge_op(s2_col == '0, &s2_col, shadow_en, PRIO_FIRST != 0, e[PLANES-1:0] == '0);
  assign merged    = m.shade ? {1'b1, e[EW-2:0]} : {e[SB], s2_pal, s2_col};
  assign draw_we   = ce_wr & s2_valid & m.we & ~ls;
  assign clr_we    = ce_px & sv & ~ls;

  // colour of the current pixel from the latched planar row
  always_comb begin
    col = hflip_l ? px_i : IW'(ROW_PX-1) - px_i;
    c = '0;
    for (int p = 0; p < PLANES; p++) c[p] = planes_l[p*ROW_PX + int'(col)];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic dr;
    assign dr = bank_sel == 1'(b);
    sprite_lb_bank #(.AW(AW), .DW(EW)) u_bank (
      .clk_24M(clk_24M),
      .we     (init | (dr ? draw_we : clr_we)),
      .wa     (init ? init_cnt : dr ? s2_addr : sa),
      .wd     (init | ~dr ? '0 : merged),
      .ra     (dr ? draw_ra : scan_ra),
      .rd     (rdb[b])
    );
  end

  // draw FSM: clear both banks, accept rows, S1 read / S2 merge-write pipeline, bank swap
  always_ff @(posedge clk_24M or negedge nRES)
    if (!nRES) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      bank_sel <= 1'b0;
      x_l      <= '0;
      hflip_l  <= 1'b0;
      pal_l    <= '0;
      planes_l <= '0;
      px_i     <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_col   <= '0;
      s2_pal   <= '0;
      s2_fwd   <= 1'b0;
      fwd_ent  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= ls & ((state == ST_DRAW) | s2_valid);
      if (ls) bank_sel <= ~bank_sel;
      if (init) begin
        init_cnt <= init_cnt + AW'(1);
        if (init_cnt == AW'(LINE_W-1)) state <= ST_IDLE;
      end else if (ls & (state == ST_DRAW)) state <= ST_IDLE;
      else if (accept) begin
        x_l      <= spr_x;
        hflip_l  <= spr_hflip;
        pal_l    <= spr_pal;
        planes_l <= spr_planes;
        px_i     <= '0;
        state    <= ST_DRAW;
      end else if (s1_fire) begin
        px_i <= px_i + IW'(1);
        if (px_i == IW'(ROW_PX-1)) state <= ST_IDLE;
      end
      if (ls | ce_wr) s2_valid <= s1_fire;
      if (s1_fire) begin
        s2_addr <= addr;
        s2_col  <= c;
        s2_pal  <= pal_l;
        s2_fwd  <= draw_we & (s2_addr == addr);
        fwd_ent <= merged;
      end
    end

  // scan: read display bank, register one ce_px later, clear the entry just read
  always_ff @(posedge clk_24M or negedge nRES)
    if (!nRES) begin
      rd_x       <= '0;
      sa         <= '0;
      sv         <= 1'b0;
      pix_out    <= '0;
      pix_opaque <= 1'b0;
      shadow     <= 1'b0;
    end else if (ls) begin
      rd_x <= '0;
      sv   <= 1'b0;
    end else if (ce_px) begin
      sa         <= scan_a;
      sv         <= ~init;
      rd_x       <= rd_x == AW'(LINE_W-1) ? rd_x : rd_x + AW'(1);
      pix_out    <= sv ? rd_s[EW-2:0] : '0;
      pix_opaque <= sv & (rd_s[PLANES-1:0] != '0);
      shadow     <= sv & rd_s[SB];
    end
endmodule
